alarm_scheduler: RTL and testbench
==================================

# alarm_scheduler

Controller that owns the single clock speaker. It sequences the user alarm through ring, snooze and timeout, and overlays the hourly chime. It arbitrates both sources onto one registered speaker line, with alarm priority over chime. It sits between the BCD timekeeping counters and the speaker driver, and consumes the same 1 kHz and 500 Hz tone nets used elsewhere in the clock.

## Interface
Parameters:
- RING_SECS, 60, seconds an un-answered alarm rings before auto-stop
- SNOOZE_SECS, 300, snooze interval in seconds
- MAX_SNOOZE, 3, snoozes allowed per alarm event

Ports:
- CLK  in  1  system clock, ≥ 4 kHz; all state on rising edge
- RST  in  1  synchronous, active-high reset
- SecTick  in  1  one-CLK pulse per second, synchronous to CLK
- Hour, Minute, Second  in  8 each  current time, packed BCD
- AlarmHour, AlarmMinute  in  8 each  alarm set time, packed BCD
- AlarmEn  in  1  alarm armed
- SnoozeKey, StopKey  in  1 each  debounced one-CLK key pulses
- _1kHzIN, _500Hz  in  1 each  tone square waves, treated as data
- Speaker  out  1  registered speaker drive
- Ringing  out  1  state == ALARM
- Snoozing  out  1  state == SNOOZE
- ChimeOn  out  1  chime currently driving Speaker
- SnoozeUsed  out  2  snoozes consumed in the current event

## Operation
- States: IDLE, ALARM, SNOOZE.
- Match: AlarmEn && Hour==AlarmHour && Minute==AlarmMinute && Second==8'h00.
- Trigger: the 0→1 edge of match, using a registered match_d that resets to 0.
- IDLE → ALARM on trigger. On entry, clear ring_cnt and SnoozeUsed.
- ALARM:
  - ring_cnt increments on SecTick.
  - StopKey → IDLE.
  - SnoozeKey with SnoozeUsed < MAX_SNOOZE → SNOOZE: SnoozeUsed+1, clear snz_cnt.
  - SnoozeKey with SnoozeUsed == MAX_SNOOZE is ignored.
  - SecTick with ring_cnt == RING_SECS-1 → IDLE.
- SNOOZE:
  - snz_cnt increments on SecTick.
  - SecTick with snz_cnt == SNOOZE_SECS-1 → ALARM, ring_cnt cleared, SnoozeUsed kept.
  - StopKey → IDLE.
  - SnoozeKey is ignored.
- AlarmEn = 0 in ALARM or SNOOZE → IDLE on the next edge.
- Trigger in ALARM or SNOOZE is ignored.
- StopKey and SnoozeKey in the same cycle: Stop wins.
- Alarm tone: _1kHzIN gated on while ring_cnt[0]==0, i.e. 1 s on / 1 s off, starting with tone.
- Chime window (combinational): Minute==8'h59, plus:
  - Second ∈ {51,53,55,57} → _500Hz
  - Second == 59 → _1kHzIN
  - otherwise 0
- Arbitration:
  - Speaker_next = alarm tone if ALARM, else chime tone if chime window, else 0.
  - ChimeOn = chime window && state != ALARM, registered.
  - A chime during SNOOZE sounds; snz_cnt keeps counting.
- Widths:
  - ring_cnt = clog2(RING_SECS) = 6 bits.
  - snz_cnt = clog2(SNOOZE_SECS) = 9 bits.
  - Counters never wrap; the terminal count forces the state exit.

## Timing
- Reset values: state IDLE; Speaker, Ringing, Snoozing, ChimeOn, SnoozeUsed, ring_cnt, snz_cnt, match_d all 0.
- RST mid-ring or mid-snooze aborts to IDLE at that edge.
- If match is already true at reset release, the alarm triggers one cycle later, because match_d resets to 0.
- Trigger seen in cycle n → Ringing=1 in cycle n+1 → Speaker carries _1kHzIN (sampled in n+1) from cycle n+2.
- Speaker has one CLK latency from the tone inputs.
- Key pulse in cycle n → state change visible in cycle n+1.
- Speaker is 0 from cycle n+2.
- Ring length: exactly RING_SECS SecTicks after entry; the exit happens on the edge after the RING_SECS-th tick.
- Snooze length: the same rule with SNOOZE_SECS.

## Structure
- Shared package/include holds:
  - state encodings (IDLE=2'd0, ALARM=2'd1, SNOOZE=2'd2)
  - BCD constants: SEC_00=8'h00; MIN_59=8'h59; chime seconds 8'h51, 8'h53, 8'h55, 8'h57, 8'h59
- Sub-module alarm_match: BCD compare plus match_d edge detect, outputting the single-cycle trigger.
- FSM, counters and speaker mux stay in alarm_scheduler.

## Test plan
- Alarm set 07:30, AlarmEn=1, time steps 07:29:59 → 07:30:00 → Ringing=1 one cycle later. Speaker follows _1kHzIN for seconds 0,2,4…, is 0 on odd seconds, and returns to IDLE after 60 SecTicks with no key.
- SnoozeKey at ring second 5 → Snoozing=1, SnoozeUsed=1, Speaker=0. After 300 SecTicks → Ringing=1 again with ring_cnt=0.
- Three snoozes followed by a fourth SnoozeKey → stays ALARM, SnoozeUsed=3. StopKey → IDLE, all outputs 0.
- Time 09:59:51 in IDLE → Speaker=_500Hz delayed one cycle, ChimeOn=1. At :52 → 0. At :59 → _1kHzIN.
- Alarm 10:59, Minute=8'h59, Second=8'h51 while ALARM with ring_cnt odd → Speaker=0, ChimeOn=0 (alarm wins). Same instant in SNOOZE → chime audible, snz_cnt still advances.
- StopKey and SnoozeKey in the same cycle → IDLE. AlarmEn dropped mid-snooze → IDLE next edge. RST asserted mid-ring → all outputs 0 at that edge.

Source files
------------

// File: rtl/alarm_scheduler_pkg.sv
// Shared types and BCD constants for the alarm scheduler.
// Also holds the hourly chime window/tone decode used by the speaker mux.
package alarm_scheduler_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAlarm  = 2'd1,
    StSnooze = 2'd2
  } state_e;

  localparam logic [7:0] SEC_00    = 8'h00;
  localparam logic [7:0] MIN_59    = 8'h59;
  localparam logic [7:0] CHIME_S51 = 8'h51;
  localparam logic [7:0] CHIME_S53 = 8'h53;
  localparam logic [7:0] CHIME_S55 = 8'h55;
  localparam logic [7:0] CHIME_S57 = 8'h57;
  localparam logic [7:0] CHIME_S59 = 8'h59;

  // High while the chime pattern is sounding: minute 59, odd seconds 51..59.
  function automatic logic chime_window(input logic [7:0] minute, input logic [7:0] second);
    return (minute == MIN_59) &&
           ((second == CHIME_S51) || (second == CHIME_S53) || (second == CHIME_S55) ||
            (second == CHIME_S57) || (second == CHIME_S59));
  endfunction

  function automatic logic chime_tone(input logic [7:0] minute, input logic [7:0] second,
                                      input logic tone_500, input logic tone_1k);
    if (!chime_window(minute, second)) begin
      return 1'b0;
    end
    return (second == CHIME_S59) ? tone_1k : tone_500;
  endfunction

endpackage

// File: rtl/alarm_scheduler_if.sv
// Bundle of time, key, tone and speaker-status signals around the alarm scheduler.
// The scheduler uses the slave view; the timekeeping/key side uses the master view.
interface alarm_scheduler_if;

  logic       SecTick;
  logic [7:0] Hour;
  logic [7:0] Minute;
  logic [7:0] Second;
  logic [7:0] AlarmHour;
  logic [7:0] AlarmMinute;
  logic       AlarmEn;
  logic       SnoozeKey;
  logic       StopKey;
  logic       _1kHzIN;
  logic       _500Hz;
  logic       Speaker;
  logic       Ringing;
  logic       Snoozing;
  logic       ChimeOn;
  logic [1:0] SnoozeUsed;

  modport master (
    output SecTick, Hour, Minute, Second, AlarmHour, AlarmMinute, AlarmEn,
    output SnoozeKey, StopKey, _1kHzIN, _500Hz,
    input  Speaker, Ringing, Snoozing, ChimeOn, SnoozeUsed
  );

  modport slave (
    input  SecTick, Hour, Minute, Second, AlarmHour, AlarmMinute, AlarmEn,
    input  SnoozeKey, StopKey, _1kHzIN, _500Hz,
    output Speaker, Ringing, Snoozing, ChimeOn, SnoozeUsed
  );

endinterface

// File: rtl/alarm_match.sv
// BCD compare of current time against the alarm setting, with rising-edge detect
// so a match that persists for a whole second fires only one trigger pulse.
module alarm_match
  import alarm_scheduler_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       alarm_en_i,
  input  logic [7:0] hour_i,
  input  logic [7:0] minute_i,
  input  logic [7:0] second_i,
  input  logic [7:0] alarm_hour_i,
  input  logic [7:0] alarm_minute_i,
  output logic       trigger_o
);

  logic match;
  logic match_q;

  always_comb begin
    match = alarm_en_i && (hour_i == alarm_hour_i) && (minute_i == alarm_minute_i) &&
            (second_i == SEC_00);
  end

  // Resets to 0, so a match already present at reset release still fires.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match;
    end
  end

  assign trigger_o = match && !match_q;

endmodule

// File: rtl/alarm_scheduler.sv
// Alarm ring/snooze/timeout sequencer with hourly chime overlay, driving one
// registered speaker line; the alarm tone always takes precedence over the chime.
module alarm_scheduler
  import alarm_scheduler_pkg::*;
#(
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_SECS = 300,
  parameter int unsigned MAX_SNOOZE  = 3
) (
  input logic              CLK,
  input logic              RST,
  alarm_scheduler_if.slave bus_io
);

  localparam int unsigned RingW = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;
  localparam int unsigned SnzW  = (SNOOZE_SECS > 1) ? $clog2(SNOOZE_SECS) : 1;

  localparam logic [RingW-1:0] RingLast = RingW'(RING_SECS - 1);
  localparam logic [SnzW-1:0]  SnzLast  = SnzW'(SNOOZE_SECS - 1);
  localparam logic [1:0]       MaxSnz   = 2'(MAX_SNOOZE);

  state_e             state_q, state_d;
  logic [RingW-1:0]   ring_cnt_q, ring_cnt_d;
  logic [SnzW-1:0]    snz_cnt_q, snz_cnt_d;
  logic [1:0]         snooze_used_q, snooze_used_d;
  logic               speaker_q, speaker_d;
  logic               chime_on_q, chime_on_d;
  logic               trigger;
  logic               alarm_tone;
  logic               chime_win;
  logic               chime_snd;

  alarm_match u_alarm_match (
    .clk_i          (CLK),
    .rst_i          (RST),
    .alarm_en_i     (bus_io.AlarmEn),
    .hour_i         (bus_io.Hour),
    .minute_i       (bus_io.Minute),
    .second_i       (bus_io.Second),
    .alarm_hour_i   (bus_io.AlarmHour),
    .alarm_minute_i (bus_io.AlarmMinute),
    .trigger_o      (trigger)
  );

  always_comb begin
    state_d       = state_q;
    ring_cnt_d    = ring_cnt_q;
    snz_cnt_d     = snz_cnt_q;
    snooze_used_d = snooze_used_q;

    unique case (state_q)
      StIdle: begin
        ring_cnt_d    = '0;
        snz_cnt_d     = '0;
        snooze_used_d = '0;
        if (trigger) begin
          state_d = StAlarm;
        end
      end

      StAlarm: begin
        if (!bus_io.AlarmEn || bus_io.StopKey) begin
          state_d       = StIdle;
          snooze_used_d = '0;
        end else if (bus_io.SnoozeKey && (snooze_used_q < MaxSnz)) begin
          state_d       = StSnooze;
          snooze_used_d = snooze_used_q + 2'd1;
          snz_cnt_d     = '0;
        end else if (bus_io.SecTick) begin
          // Terminal count exits instead of wrapping.
          if (ring_cnt_q == RingLast) begin
            state_d       = StIdle;
            snooze_used_d = '0;
          end else begin
            ring_cnt_d = ring_cnt_q + RingW'(1);
          end
        end
      end

      StSnooze: begin
        if (!bus_io.AlarmEn || bus_io.StopKey) begin
          state_d       = StIdle;
          snooze_used_d = '0;
        end else if (bus_io.SecTick) begin
          if (snz_cnt_q == SnzLast) begin
            state_d    = StAlarm;
            ring_cnt_d = '0;
          end else begin
            snz_cnt_d = snz_cnt_q + SnzW'(1);
          end
        end
      end

      default: begin
        state_d       = StIdle;
        snooze_used_d = '0;
      end
    endcase
  end

  // 1 s on / 1 s off, starting with tone on entry to the ring.
  always_comb begin
    alarm_tone = bus_io._1kHzIN && !ring_cnt_q[0];
    chime_win  = chime_window(bus_io.Minute, bus_io.Second);
    chime_snd  = chime_tone(bus_io.Minute, bus_io.Second, bus_io._500Hz, bus_io._1kHzIN);
    speaker_d  = (state_q == StAlarm) ? alarm_tone : chime_snd;
    chime_on_d = chime_win && (state_q != StAlarm);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= StIdle;
      ring_cnt_q    <= '0;
      snz_cnt_q     <= '0;
      snooze_used_q <= '0;
      speaker_q     <= 1'b0;
      chime_on_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ring_cnt_q    <= ring_cnt_d;
      snz_cnt_q     <= snz_cnt_d;
      snooze_used_q <= snooze_used_d;
      speaker_q     <= speaker_d;
      chime_on_q    <= chime_on_d;
    end
  end

  assign bus_io.Speaker    = speaker_q;
  assign bus_io.Ringing    = (state_q == StAlarm);
  assign bus_io.Snoozing   = (state_q == StSnooze);
  assign bus_io.ChimeOn    = chime_on_q;
  assign bus_io.SnoozeUsed = snooze_used_q;

  a_ring_snooze_excl : assert property (@(posedge CLK) disable iff (RST)
    !(bus_io.Ringing && bus_io.Snoozing));

  a_snooze_bound : assert property (@(posedge CLK) disable iff (RST)
    snooze_used_q <= MaxSnz);

  a_idle_clean : assert property (@(posedge CLK) disable iff (RST)
    (state_q == StIdle) |-> (snooze_used_q == 2'd0));

endmodule

// File: tb/tb_alarm_scheduler.sv
// Self-checking bench for alarm_scheduler: directed scenarios plus a randomized
// run, scored against a seconds-remaining behavioural model of the alarm clock.
module tb_alarm_scheduler;

  localparam int RING = 60;
  localparam int SNZ  = 300;
  localparam int MAXS = 3;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  alarm_scheduler_if bus ();

  alarm_scheduler #(
    .RING_SECS   (RING),
    .SNOOZE_SECS (SNZ),
    .MAX_SNOOZE  (MAXS)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .bus_io (bus)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Model: mode 0 idle, 1 ringing, 2 snoozing; time left counted down in seconds.
  int m_mode      = 0;
  int m_ring_left = RING;
  int m_snz_left  = SNZ;
  int m_used      = 0;
  bit m_spk       = 1'b0;
  bit m_chime     = 1'b0;
  bit m_prev      = 1'b0;

  function automatic int bcd(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [5:0] obs();
    return {bus.Speaker, bus.Ringing, bus.Snoozing, bus.ChimeOn, bus.SnoozeUsed};
  endfunction

  function automatic logic [5:0] model_vec();
    return {m_spk, m_mode == 1, m_mode == 2, m_chime, 2'(m_used)};
  endfunction

  task automatic model_edge();
    int sec;
    int mnt;
    bit match;
    bit trig;
    bit win;
    bit ctone;
    bit atone;
    sec   = bcd(bus.Second);
    mnt   = bcd(bus.Minute);
    match = bus.AlarmEn && (bus.Hour == bus.AlarmHour) && (bus.Minute == bus.AlarmMinute) &&
            (sec == 0);
    trig  = match && !m_prev;
    win   = (mnt == 59) && (sec >= 51) && (sec % 2 == 1);
    ctone = win ? ((sec == 59) ? bus._1kHzIN : bus._500Hz) : 1'b0;
    atone = bus._1kHzIN && (((RING - m_ring_left) % 2) == 0);
    if (RST) begin
      m_mode = 0; m_used = 0; m_spk = 0; m_chime = 0; m_prev = 0;
      return;
    end
    m_spk   = (m_mode == 1) ? atone : ctone;
    m_chime = win && (m_mode != 1);
    m_prev  = match;
    case (m_mode)
      0: if (trig) begin m_mode = 1; m_ring_left = RING; m_used = 0; end
      1: begin
        if (!bus.AlarmEn || bus.StopKey) begin
          m_mode = 0; m_used = 0;
        end else if (bus.SnoozeKey && m_used < MAXS) begin
          m_mode = 2; m_used++; m_snz_left = SNZ;
        end else if (bus.SecTick) begin
          m_ring_left--;
          if (m_ring_left == 0) begin m_mode = 0; m_used = 0; end
        end
      end
      default: begin
        if (!bus.AlarmEn || bus.StopKey) begin
          m_mode = 0; m_used = 0;
        end else if (bus.SecTick) begin
          m_snz_left--;
          if (m_snz_left == 0) begin m_mode = 1; m_ring_left = RING; end
        end
      end
    endcase
  endtask

  task automatic step();
    bus._1kHzIN = 1'($urandom);
    bus._500Hz  = 1'($urandom);
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic sec_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.SecTick = 1'b1;
      step();
      bus.SecTick = 1'b0;
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  task automatic fire_alarm();
    bus.Hour   = bus.AlarmHour;
    bus.Minute = bus.AlarmMinute;
    bus.Second = 8'h01;
    step();
    bus.Second = 8'h00;
    step();
    bus.Second = 8'h01;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    step();
    step();
    checks++;
    if (obs() !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=%b", obs(), 6'b0);
    end
    RST = 1'b0;
    step();
  endtask

  task automatic test_ring_timeout();
    int gap;
    bus.AlarmHour = 8'h07; bus.AlarmMinute = 8'h30; bus.AlarmEn = 1'b1;
    bus.Hour = 8'h07; bus.Minute = 8'h29; bus.Second = 8'h59;
    step();
    step();
    bus.Minute = 8'h30; bus.Second = 8'h00;
    step();
    checks++;
    if (bus.Ringing !== 1'b1) begin
      failures++;
      $display("FAIL ring_start got=%b exp=1", bus.Ringing);
    end
    bus.Second = 8'h01;
    step();
    checks++;
    if (bus.Speaker !== bus._1kHzIN) begin
      failures++;
      $display("FAIL ring_first_tone got=%b exp=%b", bus.Speaker, bus._1kHzIN);
    end
    for (int t = 0; t < RING; t++) begin
      bus.SecTick = 1'b1;
      step();
      bus.SecTick = 1'b0;
      checks++;
      if (obs() !== model_vec()) begin
        failures++;
        $display("FAIL ring_tick%0d got=%b exp=%b", t, obs(), model_vec());
      end
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        step();
        checks++;
        if (obs() !== model_vec()) begin
          failures++;
          $display("FAIL ring_gap%0d got=%b exp=%b", t, obs(), model_vec());
        end
      end
    end
    checks++;
    if (bus.Ringing !== 1'b0) begin
      failures++;
      $display("FAIL ring_timeout got=%b exp=0", bus.Ringing);
    end
    step();
    checks++;
    if (bus.Speaker !== 1'b0) begin
      failures++;
      $display("FAIL ring_timeout_spk got=%b exp=0", bus.Speaker);
    end
  endtask

  task automatic test_snooze();
    fire_alarm();
    sec_ticks(5);
    bus.SnoozeKey = 1'b1;
    step();
    bus.SnoozeKey = 1'b0;
    checks++;
    if ({bus.Ringing, bus.Snoozing, bus.SnoozeUsed} !== 4'b0101) begin
      failures++;
      $display("FAIL snooze_enter got=%b exp=0101", {bus.Ringing, bus.Snoozing, bus.SnoozeUsed});
    end
    step();
    checks++;
    if (bus.Speaker !== 1'b0) begin
      failures++;
      $display("FAIL snooze_quiet got=%b exp=0", bus.Speaker);
    end
    for (int t = 0; t < SNZ; t++) begin
      bus.SecTick = 1'b1;
      step();
      bus.SecTick = 1'b0;
      checks++;
      if (obs() !== model_vec()) begin
        failures++;
        $display("FAIL snooze_tick%0d got=%b exp=%b", t, obs(), model_vec());
      end
      if ($urandom_range(0, 1) == 1) step();
    end
    checks++;
    if ({bus.Ringing, bus.Snoozing, bus.SnoozeUsed} !== 4'b1001) begin
      failures++;
      $display("FAIL snooze_rering got=%b exp=1001", {bus.Ringing, bus.Snoozing, bus.SnoozeUsed});
    end
    step();
    checks++;
    if (bus.Speaker !== bus._1kHzIN) begin
      failures++;
      $display("FAIL rering_tone got=%b exp=%b", bus.Speaker, bus._1kHzIN);
    end
  endtask

  task automatic test_snooze_limit();
    for (int s = 0; s < 2; s++) begin
      bus.SnoozeKey = 1'b1;
      step();
      bus.SnoozeKey = 1'b0;
      sec_ticks(SNZ);
    end
    bus.SnoozeKey = 1'b1;
    step();
    bus.SnoozeKey = 1'b0;
    checks++;
    if ({bus.Ringing, bus.Snoozing, bus.SnoozeUsed} !== 4'b1011) begin
      failures++;
      $display("FAIL snooze_limit got=%b exp=1011", {bus.Ringing, bus.Snoozing, bus.SnoozeUsed});
    end
    bus.StopKey = 1'b1;
    step();
    bus.StopKey = 1'b0;
    step();
    checks++;
    if (obs() !== 6'b0) begin
      failures++;
      $display("FAIL stop_all_zero got=%b exp=%b", obs(), 6'b0);
    end
  endtask

  task automatic test_chime();
    bus.AlarmEn = 1'b0;
    bus.Hour = 8'h09; bus.Minute = 8'h59; bus.Second = 8'h51;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({bus.Speaker, bus.ChimeOn} !== {bus._500Hz, 1'b1}) begin
        failures++;
        $display("FAIL chime_51 got=%b exp=%b", {bus.Speaker, bus.ChimeOn}, {bus._500Hz, 1'b1});
      end
    end
    bus.Second = 8'h52;
    step();
    checks++;
    if (bus.Speaker !== 1'b0) begin
      failures++;
      $display("FAIL chime_52 got=%b exp=0", bus.Speaker);
    end
    bus.Second = 8'h59;
    step();
    checks++;
    if ({bus.Speaker, bus.ChimeOn} !== {bus._1kHzIN, 1'b1}) begin
      failures++;
      $display("FAIL chime_59 got=%b exp=%b", {bus.Speaker, bus.ChimeOn}, {bus._1kHzIN, 1'b1});
    end
    bus.Minute = 8'h00; bus.Second = 8'h00; bus.AlarmEn = 1'b1;
    step();
  endtask

  task automatic test_chime_overlay();
    bus.AlarmHour = 8'h10; bus.AlarmMinute = 8'h59;
    fire_alarm();
    bus.SecTick = 1'b1;
    step();
    bus.SecTick = 1'b0;
    bus.Second = 8'h51;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({bus.Speaker, bus.ChimeOn} !== 2'b00) begin
        failures++;
        $display("FAIL alarm_over_chime got=%b exp=00", {bus.Speaker, bus.ChimeOn});
      end
    end
    bus.SnoozeKey = 1'b1;
    step();
    bus.SnoozeKey = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({bus.Speaker, bus.ChimeOn} !== {bus._500Hz, 1'b1}) begin
        failures++;
        $display("FAIL chime_in_snooze got=%b exp=%b", {bus.Speaker, bus.ChimeOn},
                 {bus._500Hz, 1'b1});
      end
    end
    for (int t = 0; t < SNZ; t++) begin
      bus.SecTick = 1'b1;
      step();
      bus.SecTick = 1'b0;
      checks++;
      if (obs() !== model_vec()) begin
        failures++;
        $display("FAIL snooze_chime_tick%0d got=%b exp=%b", t, obs(), model_vec());
      end
    end
    checks++;
    if (bus.Ringing !== 1'b1) begin
      failures++;
      $display("FAIL snooze_count_with_chime got=%b exp=1", bus.Ringing);
    end
    bus.StopKey = 1'b1;
    step();
    bus.StopKey = 1'b0;
    bus.Second = 8'h01;
    step();
  endtask

  task automatic test_keys_together();
    bus.AlarmHour = 8'h07; bus.AlarmMinute = 8'h30;
    fire_alarm();
    bus.StopKey = 1'b1; bus.SnoozeKey = 1'b1;
    step();
    bus.StopKey = 1'b0; bus.SnoozeKey = 1'b0;
    checks++;
    if ({bus.Ringing, bus.Snoozing, bus.SnoozeUsed} !== 4'b0000) begin
      failures++;
      $display("FAIL stop_beats_snooze got=%b exp=0000",
               {bus.Ringing, bus.Snoozing, bus.SnoozeUsed});
    end
  endtask

  task automatic test_en_drop();
    fire_alarm();
    bus.SnoozeKey = 1'b1;
    step();
    bus.SnoozeKey = 1'b0;
    sec_ticks(3);
    bus.AlarmEn = 1'b0;
    step();
    checks++;
    if ({bus.Ringing, bus.Snoozing} !== 2'b00) begin
      failures++;
      $display("FAIL en_drop got=%b exp=00", {bus.Ringing, bus.Snoozing});
    end
    bus.AlarmEn = 1'b1;
    step();
  endtask

  task automatic test_rst_mid_ring();
    fire_alarm();
    sec_ticks(2);
    RST = 1'b1;
    step();
    checks++;
    if (obs() !== 6'b0) begin
      failures++;
      $display("FAIL rst_mid_ring got=%b exp=%b", obs(), 6'b0);
    end
    RST = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic [7:0] secs [6];
    logic [7:0] mins [3];
    secs = '{8'h00, 8'h01, 8'h51, 8'h52, 8'h57, 8'h59};
    mins = '{8'h59, 8'h30, 8'h58};
    bus.AlarmHour = 8'h10; bus.AlarmMinute = 8'h59;
    for (int c = 0; c < 4000; c++) begin
      bus.SecTick   = ($urandom_range(0, 2) == 0);
      bus.SnoozeKey = ($urandom_range(0, 40) == 0);
      bus.StopKey   = ($urandom_range(0, 150) == 0);
      bus.AlarmEn   = ($urandom_range(0, 300) != 0);
      RST           = ($urandom_range(0, 1500) == 0);
      if ($urandom_range(0, 20) == 0) begin
        bus.Hour   = ($urandom_range(0, 3) == 0) ? 8'h11 : 8'h10;
        bus.Minute = mins[$urandom_range(0, 2)];
        bus.Second = secs[$urandom_range(0, 5)];
      end
      step();
      checks++;
      if (obs() !== model_vec()) begin
        failures++;
        $display("FAIL random_c%0d got=%b exp=%b", c, obs(), model_vec());
      end
    end
    RST = 1'b0; bus.SecTick = 1'b0; bus.SnoozeKey = 1'b0; bus.StopKey = 1'b0;
  endtask

  initial begin
    bus.SecTick = 1'b0; bus.Hour = 8'h00; bus.Minute = 8'h00; bus.Second = 8'h00;
    bus.AlarmHour = 8'h00; bus.AlarmMinute = 8'h00; bus.AlarmEn = 1'b0;
    bus.SnoozeKey = 1'b0; bus.StopKey = 1'b0; bus._1kHzIN = 1'b0; bus._500Hz = 1'b0;
    test_reset();
    test_ring_timeout();
    test_snooze();
    test_snooze_limit();
    test_chime();
    test_chime_overlay();
    test_keys_together();
    test_en_drop();
    test_rst_mid_ring();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
